// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for the RAM_wrapper port (optional watchdog: MAU_TIMEOUT_EN)
module mem_access_unit #(
    parameter int W = 32
`ifdef MAU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic [1:0]   en,
    output logic [W-1:0] addr_rd,
    output logic [W-1:0] addr_w,
    output logic [W-1:0] dwrite,
    input  logic [W-1:0] dout,
    input  logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic         we_q;
    logic [W-1:0] addr_q;
    logic [W-1:0] wdata_q;
    logic [W-1:0] rdata_q;
    logic         accept;
    logic         active;
    logic         timeout_hit;

    assign accept = req_valid && req_ready;
    assign active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

`ifdef MAU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] wd_cnt_q;
    logic          err_q;

    assign timeout_hit = active && (wd_cnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                wd_cnt_q <= '0;
                err_q    <= 1'b0;
            end else if (timeout_hit) begin
                err_q    <= 1'b1;
            end else if (active) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end

    assign rsp_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are frozen at accept so the wrapper sees stable addr/data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Load data is captured on the same edge that leaves WAIT; stores leave it untouched.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (timeout_hit) begin
            rdata_q <= '0;
        end else if ((state_q == ST_WAIT) && !busy && !we_q) begin
            rdata_q <= dout;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (timeout_hit)  state_d = ST_DONE;
                else if (busy)    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (timeout_hit)  state_d = ST_DONE;
                else if (!busy)   state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        en        = 2'b00;
        case (state_q)
            ST_IDLE:  req_ready = !busy;
            ST_ISSUE: en        = we_q ? 2'b10 : 2'b01;
            ST_DONE:  rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    assign addr_rd   = addr_q;
    assign addr_w    = addr_q;
    assign dwrite    = wdata_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit (MAU_TIMEOUT_EN optional)
module tb_mem_access_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [W-1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic         rsp_valid;
    logic [W-1:0] rsp_rdata;
    logic         rsp_err;
    logic [1:0]   en;
    logic [W-1:0] addr_rd;
    logic [W-1:0] addr_w;
    logic [W-1:0] dwrite;
    logic [W-1:0] dout;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] ref_mem [256];
    logic [W-1:0] wmem    [256];
    logic [W-1:0] last_rdata;
    logic         cur_we;
    logic [W-1:0] cur_addr;
    logic [W-1:0] cur_wdata;
    logic         force_busy;
    logic [1:0]   bcnt;

    always #5 clk = ~clk;

    mem_access_unit #(.W(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .en        (en),
        .addr_rd   (addr_rd),
        .addr_w    (addr_w),
        .dwrite    (dwrite),
        .dout      (dout),
        .busy      (busy)
    );

    // Wrapper model: busy rises one cycle after a nonzero en and stays high for two cycles.
    assign busy = force_busy || (bcnt != 2'd0);

    always @(posedge clk) begin
        if (!rstn) begin
            bcnt <= 2'd0;
            dout <= '0;
            for (int i = 0; i < 256; i++) wmem[i] <= '0;
        end else if (bcnt != 2'd0) begin
            bcnt <= bcnt - 2'd1;
        end else if (en != 2'b00) begin
            bcnt <= 2'd2;
            if (en == 2'b10) wmem[addr_w] <= dwrite;
            else             dout <= wmem[addr_rd];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        last_rdata = '0;
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic accept(input logic we, input logic [W-1:0] a, input logic [W-1:0] d,
                          output int waited);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        waited    = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check_eq("accept_bound", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cur_we    = we;
        cur_addr  = a;
        cur_wdata = d;
        if (we) ref_mem[a] = d;
        else    last_rdata = ref_mem[a];
    endtask

    task automatic wait_rsp(input int exp_lat);
        int   k     = 0;
        int   issue = 0;
        logic seen  = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            check_eq("req_ready_low", {31'd0, req_ready}, 32'd0);
            if (en != 2'b00) begin
                issue++;
                check_eq("en_code", {30'd0, en}, cur_we ? 32'd2 : 32'd1);
                if (cur_we) begin
                    check_eq("addr_w", {24'd0, addr_w}, {24'd0, cur_addr});
                    check_eq("dwrite", {24'd0, dwrite}, {24'd0, cur_wdata});
                end else begin
                    check_eq("addr_rd", {24'd0, addr_rd}, {24'd0, cur_addr});
                end
            end
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("rsp_seen", {31'd0, seen}, 32'd1);
        check_eq("latency", k - 1, exp_lat);
        check_eq("issue_cycles", issue, 32'd2);
        check_eq("rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, last_rdata});
        @(negedge clk);
        check_eq("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int w;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        force_busy = 1'b0;
        cur_we     = 1'b0;
        cur_addr   = '0;
        cur_wdata  = '0;
        ref_clear();
        repeat (3) @(negedge clk);
        check_eq("rst_en", {30'd0, en}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        check_eq("rst_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_addr_w", {24'd0, addr_w}, 32'd0);
        check_eq("rst_dwrite", {24'd0, dwrite}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);

        // Directed store then load of the same location.
        accept(1'b1, 8'h12, 8'hA5, w);
        wait_rsp(4);
        accept(1'b0, 8'h12, 8'h00, w);
        wait_rsp(4);
        check_eq("load_a5", {24'd0, rsp_rdata}, 32'hA5);

        // Second request held valid throughout an active load.
        accept(1'b0, 8'h12, 8'h00, w);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h34;
        req_wdata = 8'h5C;
        wait_rsp(4);
        accept(1'b1, 8'h34, 8'h5C, w);
        check_eq("held_accept_wait", w, 32'd0);
        wait_rsp(4);
        accept(1'b0, 8'h34, 8'h00, w);
        wait_rsp(4);

        // Wrapper busy at IDLE blocks acceptance.
        force_busy = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 8'h12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("busy_blocks_ready", {31'd0, req_ready}, 32'd0);
            check_eq("busy_idle_en", {30'd0, en}, 32'd0);
        end
        force_busy = 1'b0;
        accept(1'b0, 8'h12, 8'h00, w);
        wait_rsp(4);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            logic         we;
            logic [W-1:0] a, d;
            we = 1'($urandom_range(0, 1));
            a  = W'($urandom_range(0, 15));
            d  = W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            accept(we, a, d, w);
            wait_rsp(4);
        end

        // Reset while in WAIT aborts without a response.
        accept(1'b0, 8'h12, 8'h00, w);
        repeat (3) @(negedge clk);
        check_eq("in_wait_en", {30'd0, en}, 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("abort_en", {30'd0, en}, 32'd0);
        check_eq("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rstn = 1'b1;
        ref_clear();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
        check_eq("abort_rdata", {24'd0, rsp_rdata}, 32'd0);
        accept(1'b1, 8'h07, 8'h3C, w);
        wait_rsp(4);
        accept(1'b0, 8'h07, 8'h00, w);
        wait_rsp(4);

`ifdef MAU_TIMEOUT_EN
        // Wrapper never releases busy: watchdog ends the access.
        begin
            int   k    = 0;
            logic seen = 1'b0;
            accept(1'b0, 8'h07, 8'h00, w);
            force_busy = 1'b1;
            while (!seen && k < 200) begin
                @(negedge clk);
                k++;
                if (rsp_valid) seen = 1'b1;
            end
            check_eq("to_seen", {31'd0, seen}, 32'd1);
            check_eq("to_latency", k - 1, 32'd64);
            check_eq("to_err", {31'd0, rsp_err}, 32'd1);
            check_eq("to_rdata", {24'd0, rsp_rdata}, 32'd0);
            check_eq("to_en", {30'd0, en}, 32'd0);
            force_busy = 1'b0;
            last_rdata = '0;
            @(negedge clk);
            check_eq("to_err_held", {31'd0, rsp_err}, 32'd1);
            accept(1'b1, 8'h21, 8'h99, w);
            wait_rsp(4);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
